// File: rtl/neureka_quant_packer_if.sv
// rtl/neureka_quant_packer_if.sv - stream bundle for neureka_quant_packer
// Input beat stream (streamer side) and packed output word stream (memory side).
interface neureka_quant_packer_if #(
  parameter int NADD      = 8,
  parameter int QNT       = 32,
  parameter int OUT_BYTES = 32
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [NADD*QNT-1:0]    in_data_i;
  logic                   in_last_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [OUT_BYTES*8-1:0] out_data_o;
  logic [OUT_BYTES-1:0]   out_strb_o;
  logic                   out_last_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_strb_o, out_last_o
  );
endinterface

// File: rtl/neureka_quant_packer.sv
// rtl/neureka_quant_packer.sv - clamp NADD lanes to 8 bits and pack BEATS beats per output word
// Optional lane-saturation counter enabled by defining NEUREKA_PACK_STATS_EN.
module neureka_quant_packer #(
  parameter int NADD      = 8,
  parameter int QNT       = 32,
  parameter int OUT_BYTES = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 relu_en_i,
  neureka_quant_packer_if.slave bus,
  output logic [15:0]          sat_count_o
);

  localparam int BEATS = OUT_BYTES / NADD;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = OUT_BYTES * 8;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [7:0] clamp_byte(input logic signed [QNT-1:0] x, input logic relu);
    logic [7:0] r;
    if (relu) begin
      if (x < 0)         r = 8'h00;
      else if (x > 255)  r = 8'hFF;
      else               r = x[7:0];
    end else begin
      if (x < -128)      r = 8'h80;
      else if (x > 127)  r = 8'h7F;
      else               r = x[7:0];
    end
    return r;
  endfunction

  logic [0:0]           state_q, state_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]        asm_data_q, asm_data_d;
  logic [OUT_BYTES-1:0] asm_strb_q, asm_strb_d;
  logic                 hold_last_q, hold_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [OUT_BYTES-1:0] out_strb_q, out_strb_d;
  logic                 out_last_q, out_last_d;

  logic [7:0]           lane_byte [NADD];
  logic [DW-1:0]        merged_data;
  logic [OUT_BYTES-1:0] merged_strb;
  logic                 in_ready;
  logic                 accept;
  logic                 slot_free;
  logic                 word_done;

  assign in_ready  = (state_q == ST_FILL);
  assign accept    = bus.in_valid_i && in_ready;
  assign slot_free = !out_valid_q || bus.out_ready_i;
  assign word_done = (beat_cnt_q == BW'(BEATS - 1)) || bus.in_last_i;

  always_comb begin
    for (int ii = 0; ii < NADD; ii++) begin
      lane_byte[ii] = clamp_byte(bus.in_data_i[ii*QNT +: QNT], relu_en_i);
    end
  end

  // Assembly buffer with the current beat dropped into its slot.
  always_comb begin
    merged_data = asm_data_q;
    merged_strb = asm_strb_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt_q == BW'(b)) begin
        for (int ii = 0; ii < NADD; ii++) begin
          merged_data[(b*NADD+ii)*8 +: 8] = lane_byte[ii];
          merged_strb[b*NADD+ii]          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    asm_data_d  = asm_data_q;
    asm_strb_d  = asm_strb_q;
    hold_last_d = hold_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;

    if (out_valid_q && bus.out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (word_done) begin
            beat_cnt_d = '0;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_data_d  = merged_data;
              out_strb_d  = merged_strb;
              out_last_d  = bus.in_last_i;
              asm_data_d  = '0;
              asm_strb_d  = '0;
            end else begin
              asm_data_d  = merged_data;
              asm_strb_d  = merged_strb;
              hold_last_d = bus.in_last_i;
              state_d     = ST_HOLD;
            end
          end else begin
            asm_data_d = merged_data;
            asm_strb_d = merged_strb;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // out_valid is necessarily high here, so out_ready alone frees the slot.
        if (bus.out_ready_i) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_data_q;
          out_strb_d  = asm_strb_q;
          out_last_d  = hold_last_q;
          asm_data_d  = '0;
          asm_strb_d  = '0;
          beat_cnt_d  = '0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (clear_i) begin
      state_d     = ST_FILL;
      beat_cnt_d  = '0;
      asm_data_d  = '0;
      asm_strb_d  = '0;
      hold_last_d = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FILL;
      beat_cnt_q  <= '0;
      asm_data_q  <= '0;
      asm_strb_q  <= '0;
      hold_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      asm_data_q  <= asm_data_d;
      asm_strb_q  <= asm_strb_d;
      hold_last_q <= hold_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_strb_o  = out_strb_q;
  assign bus.out_last_o  = out_last_q;

`ifdef NEUREKA_PACK_STATS_EN
  localparam int SW = $clog2(NADD + 1);

  function automatic logic lane_clamped(input logic signed [QNT-1:0] x, input logic relu);
    return relu ? (x < 0 || x > 255) : (x < -128 || x > 127);
  endfunction

  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [SW-1:0] sat_n;
  logic [16:0]   sat_sum;

  always_comb begin
    sat_n = '0;
    for (int ii = 0; ii < NADD; ii++) begin
      sat_n = sat_n + SW'(lane_clamped(bus.in_data_i[ii*QNT +: QNT], relu_en_i));
    end
    sat_sum   = {1'b0, sat_cnt_q} + 17'(sat_n);
    sat_cnt_d = sat_cnt_q;
    if (accept) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    if (clear_i) sat_cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count_o = sat_cnt_q;
`else
  assign sat_count_o = 16'h0;
`endif

endmodule
